// File: rtl/hififo_fetch_descriptor_mc.sv
// hififo_fetch_descriptor_mc
//   Multi-channel descriptor fetch engine. Each channel owns a descriptor
//   FIFO, a transfer address/length generator, a byte counter with a match
//   interrupt and a 4-state fetch controller. The descriptor block read
//   requests of all channels share one read-request port through a
//   round-robin arbiter.
//
// Ports
//   clock, reset          sole clock, synchronous active-high reset
//   wdata/wvalid/wchan    tagged command/descriptor write bus
//   rc_last/rc_chan       last completion of a descriptor block read
//   rr_valid/rr_addr/rr_chan/rr_ready
//                         descriptor block read request port
//   request_addr          per-channel transfer address (flat, ch0 in LSBs)
//   request_count         per-channel remaining granules
//   request_valid         per-channel request_count != 0
//   request_ack           per-channel one granule consumed
//   status                per-channel {byte_count, zeros, request_valid, idle}
//   interrupt             [2c] byte match pulse, [2c+1] went-idle pulse
//
// Read-request handshake: rr_valid rises with rr_addr/rr_chan and all three
// hold constant until the cycle rr_valid && rr_ready is sampled high; that
// cycle is the transfer. rr_valid then drops for at least one cycle.
module hififo_fetch_descriptor_mc #(
  parameter int NCH    = 4,
  parameter int BS     = 3,
  parameter int AMSB   = 63,
  parameter int DMSB   = 63,
  parameter int SMSB   = 31,
  parameter int LMSB   = 16,
  parameter int FDEPTH = 128,
  parameter int CB     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [DMSB:0]                wdata,
  input  logic                         wvalid,
  input  logic [CB-1:0]                wchan,
  input  logic                         rc_last,
  input  logic [CB-1:0]                rc_chan,
  output logic                         rr_valid,
  output logic [AMSB:0]                rr_addr,
  output logic [CB-1:0]                rr_chan,
  input  logic                         rr_ready,
  output logic [NCH*(AMSB+1)-1:0]      request_addr,
  output logic [NCH*(LMSB-BS+1)-1:0]   request_count,
  output logic [NCH-1:0]               request_valid,
  input  logic [NCH-1:0]               request_ack,
  output logic [NCH*(SMSB+1)-1:0]      status,
  output logic [2*NCH-1:0]             interrupt
);

  localparam int AW = AMSB - BS + 1;   // granule address width
  localparam int LW = LMSB - BS + 1;   // granule count width
  localparam int BW = SMSB - BS + 1;   // byte counter width
  localparam int NW = AMSB - 8;        // 512-byte block address width
  localparam int FW = $clog2(FDEPTH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HAVEADDR = 2'd1,
    S_PENDING  = 2'd2,
    S_WAIT     = 2'd3
  } fetch_state_e;

  logic [NCH-1:0]         pending;
  logic [NCH-1:0][NW-1:0] next_desc;

  logic                   rr_valid_q;
  logic [CB-1:0]          rr_chan_q;
  logic [AMSB:0]          rr_addr_q;
  logic [CB-1:0]          ptr_q;
  logic                   accept;
  logic                   sel_found;
  logic [CB-1:0]          sel_chan;
  logic [CB:0]            arb_idx;

  assign accept   = rr_valid_q & rr_ready;
  assign rr_valid = rr_valid_q;
  assign rr_addr  = rr_addr_q;
  assign rr_chan  = rr_chan_q;

  // ptr_q is the first channel searched; it moves past a channel only once
  // that channel's request has been accepted.
  always_comb begin
    sel_found = 1'b0;
    sel_chan  = '0;
    arb_idx   = '0;
    for (int i = 0; i < NCH; i++) begin
      arb_idx = {1'b0, ptr_q} + (CB+1)'(i);
      if (arb_idx >= (CB+1)'(NCH)) arb_idx = arb_idx - (CB+1)'(NCH);
      if (!sel_found && pending[arb_idx[CB-1:0]]) begin
        sel_found = 1'b1;
        sel_chan  = arb_idx[CB-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_valid_q <= 1'b0;
      ptr_q      <= '0;
    end else if (rr_valid_q) begin
      if (rr_ready) begin
        rr_valid_q <= 1'b0;
        ptr_q      <= (rr_chan_q == CB'(NCH-1)) ? '0 : rr_chan_q + CB'(1);
      end
    end else if (sel_found) begin
      // Address captured at grant so a later desc-addr write cannot move it.
      rr_valid_q <= 1'b1;
      rr_chan_q  <= sel_chan;
      rr_addr_q  <= {next_desc[sel_chan], 9'b0};
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    fetch_state_e    state_q;
    logic            abort_q, abort_d, roa_q;
    logic [NW-1:0]   desc_q;
    logic [BW-1:0]   matchval_q, byte_count_q;
    logic [DMSB:0]   mem_q [FDEPTH];
    logic [FW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FW:0]     fcount_q;
    logic [AW-1:0]   addr_high_q;
    logic [LW-1:0]   req_count_q;
    logic            hit, match_wr, push_wr, desc_wr, abort_wr;
    logic            head_valid, fifo_full, fifo_room, push, pop, ack_ok;
    logic            rc_hit, granted;
    logic [DMSB:0]   head;
    logic            match_now, idle_now;
    logic            match_prev_q, idle_prev_q, irq_match_q, irq_idle_q;
    logic [SMSB:0]   status_w;

    assign hit      = wvalid && (wchan == CB'(g));
    assign match_wr = hit && (wdata[2:0] == 3'd1);
    assign push_wr  = hit && (wdata[2:1] == 2'b01);
    assign desc_wr  = hit && (wdata[3:0] == 4'd4);
    assign abort_wr = hit && (wdata[3:0] == 4'd5);
    assign abort_d  = abort_wr ? wdata[8] : abort_q;

    assign head       = mem_q[rd_ptr_q];
    assign head_valid = (fcount_q != '0);
    assign fifo_full  = fcount_q[FW];
    assign fifo_room  = (fcount_q <= (FW+1)'(FDEPTH - 64));
    assign push       = push_wr && !fifo_full && !roa_q;
    // The head is only consumed once the current transfer has drained.
    assign pop        = head_valid && (req_count_q == '0);
    assign ack_ok     = request_ack[g] && (req_count_q != '0);
    assign rc_hit     = rc_last && (rc_chan == CB'(g));
    assign granted    = accept && (rr_chan_q == CB'(g));

    assign match_now  = (matchval_q == byte_count_q);
    assign idle_now   = (state_q == S_IDLE);

    always_ff @(posedge clock) begin
      if (reset) begin
        state_q      <= S_IDLE;
        abort_q      <= 1'b0;
        roa_q        <= 1'b1;
        matchval_q   <= '1;
        byte_count_q <= '0;
        // Previous-level registers preset high so leaving reset never
        // looks like a rising edge.
        match_prev_q <= 1'b1;
        idle_prev_q  <= 1'b1;
        irq_match_q  <= 1'b0;
        irq_idle_q   <= 1'b0;
      end else begin
        abort_q      <= abort_d;
        roa_q        <= abort_d;
        if (match_wr) matchval_q <= wdata[SMSB:BS];
        if (desc_wr)  desc_q     <= wdata[AMSB:9];
        if (ack_ok)   byte_count_q <= byte_count_q + BW'(1);
        match_prev_q <= match_now;
        idle_prev_q  <= idle_now;
        irq_match_q  <= match_now & ~match_prev_q;
        irq_idle_q   <= idle_now & ~idle_prev_q;
        case (state_q)
          S_IDLE:     if (desc_wr)   state_q <= S_HAVEADDR;
          S_HAVEADDR: if (fifo_room) state_q <= S_PENDING;
          S_PENDING:  if (granted)   state_q <= S_WAIT;
          S_WAIT:     if (rc_hit)    state_q <= desc_wr ? S_HAVEADDR : S_IDLE;
          default:                   state_q <= S_IDLE;
        endcase
      end
    end

    always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= wdata;
    end

    // roa_q follows reset/abort one cycle late; the direct reset term makes
    // the reset values appear on the first reset edge as well.
    always_ff @(posedge clock) begin
      if (reset || roa_q) begin
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        fcount_q    <= '0;
        req_count_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + FW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + FW'(1);
        case ({push, pop})
          2'b10:   fcount_q <= fcount_q + (FW+1)'(1);
          2'b01:   fcount_q <= fcount_q - (FW+1)'(1);
          default: ;
        endcase
        if (pop) begin
          if (head[2:0] == 3'd2)      addr_high_q <= head[AMSB:BS];
          else if (head[2:0] == 3'd3) req_count_q <= head[LMSB:BS];
        end else if (ack_ok) begin
          addr_high_q <= addr_high_q + AW'(1);
          req_count_q <= req_count_q - LW'(1);
        end
      end
    end

    always_comb begin
      status_w          = '0;
      status_w[SMSB:BS] = byte_count_q;
      status_w[1]       = (req_count_q != '0);
      status_w[0]       = idle_now;
    end

    assign pending[g]      = (state_q == S_PENDING);
    assign next_desc[g]    = desc_q;
    assign request_valid[g] = (req_count_q != '0);
    assign request_addr[g*(AMSB+1) +: (AMSB+1)] = {addr_high_q, {BS{1'b0}}};
    assign request_count[g*LW +: LW]            = req_count_q;
    assign status[g*(SMSB+1) +: (SMSB+1)]       = status_w;
    assign interrupt[2*g]                       = irq_match_q;
    assign interrupt[2*g+1]                     = irq_idle_q;
  end

endmodule

// File: tb/tb_hififo_fetch_descriptor_mc.sv
module tb_hififo_fetch_descriptor_mc;

  localparam int NCH = 4;
  localparam int CB  = 2;
  localparam int LW  = 14;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                reset;
  logic [63:0]         wdata;
  logic                wvalid;
  logic [CB-1:0]       wchan;
  logic                rc_last;
  logic [CB-1:0]       rc_chan;
  logic                rr_valid;
  logic [63:0]         rr_addr;
  logic [CB-1:0]       rr_chan;
  logic                rr_ready;
  logic [NCH*64-1:0]   request_addr;
  logic [NCH*LW-1:0]   request_count;
  logic [NCH-1:0]      request_valid;
  logic [NCH-1:0]      request_ack;
  logic [NCH*32-1:0]   status;
  logic [2*NCH-1:0]    interrupt;

  hififo_fetch_descriptor_mc dut (
    .clock(clock), .reset(reset),
    .wdata(wdata), .wvalid(wvalid), .wchan(wchan),
    .rc_last(rc_last), .rc_chan(rc_chan),
    .rr_valid(rr_valid), .rr_addr(rr_addr), .rr_chan(rr_chan), .rr_ready(rr_ready),
    .request_addr(request_addr), .request_count(request_count),
    .request_valid(request_valid), .request_ack(request_ack),
    .status(status), .interrupt(interrupt)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int n_acc = 0;
  int acc_target = 0;
  logic [95:0] exp_rr_q[$];
  logic [7:0]  exp_irq_q[$];
  logic [95:0] mon_e;
  logic [7:0]  mon_i;

  task automatic cmp(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] rr_exp(input int c, input logic [63:0] a);
    return {30'b0, 2'(c), a};
  endfunction

  function automatic logic [LW-1:0] cnt(input int c);
    return request_count[c*LW +: LW];
  endfunction

  function automatic logic [63:0] raddr(input int c);
    return request_addr[c*64 +: 64];
  endfunction

  function automatic logic [31:0] stat(input int c);
    return status[c*32 +: 32];
  endfunction

  // Monitor: every accepted read request and every interrupt pulse is
  // matched against the head of its expected queue.
  always @(negedge clock) begin
    if (rr_valid && rr_ready) begin
      n_acc++;
      if (exp_rr_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rr_unexpected: got chan %0d addr %0h expected none", rr_chan, rr_addr);
      end else begin
        mon_e = exp_rr_q.pop_front();
        cmp("rr_accept", {30'b0, rr_chan, rr_addr}, mon_e);
      end
    end
    for (int b = 0; b < 2*NCH; b++) begin
      if (interrupt[b] === 1'b1) begin
        if (exp_irq_q.size() == 0) begin
          total++; bad++;
          $display("FAIL irq_unexpected: got bit %0d expected none", b);
        end else begin
          mon_i = exp_irq_q.pop_front();
          cmp("irq_index", 96'(b), 96'(mon_i));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int ch, input logic [63:0] d);
    wvalid = 1'b1; wchan = CB'(ch); wdata = d;
    step();
    wvalid = 1'b0;
  endtask

  task automatic rc_pulse(input int ch);
    rc_last = 1'b1; rc_chan = CB'(ch);
    step();
    rc_last = 1'b0;
  endtask

  task automatic wait_acc(input int target);
    int i;
    i = 0;
    while (n_acc < target && i < 50) begin
      step();
      i++;
    end
    cmp("accept_count", 96'(n_acc), 96'(target));
  endtask

  task automatic check_reset_outputs(input string tag);
    cmp({tag, "_rr_valid"}, 96'(rr_valid), 96'(0));
    cmp({tag, "_request_valid"}, 96'(request_valid), 96'(0));
    cmp({tag, "_request_count"}, 96'(request_count), 96'(0));
    cmp({tag, "_interrupt"}, 96'(interrupt), 96'(0));
    for (int c = 0; c < NCH; c++) cmp({tag, "_status"}, 96'(stat(c)), 96'h1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; wvalid = 1'b0; wdata = '0; wchan = '0;
    rc_last = 1'b0; rc_chan = '0; rr_ready = 1'b0; request_ack = '0;
    step(); step(); step();
    check_reset_outputs("reset");
    reset = 1'b0;
    step(); step();

    // Single-channel fetch and transfer on channel 1.
    rr_ready = 1'b1;
    exp_rr_q.push_back(rr_exp(1, 64'h1000));
    acc_target = 1;
    wr(1, 64'h1004);
    wait_acc(acc_target);
    wr(1, 64'h2_0002);
    wr(1, 64'h43);
    step(); step();
    cmp("t1_request_addr", 96'(raddr(1)), 96'h2_0000);
    cmp("t1_request_count", 96'(cnt(1)), 96'd8);
    cmp("t1_request_valid", 96'(request_valid), 96'b0010);
    exp_irq_q.push_back(8'd3);
    rc_pulse(1);
    request_ack = 4'b0010;
    repeat (8) step();
    request_ack = '0;
    cmp("t1_count_done", 96'(cnt(1)), 96'd0);
    cmp("t1_status", 96'(stat(1)), 96'h41);
    cmp("t1_addr_end", 96'(raddr(1)), 96'h2_0040);
    request_ack = 4'b0010;
    step();
    request_ack = '0;
    step();
    cmp("t1_ack_ignored", 96'(stat(1)), 96'h41);

    // Round-robin across all four channels with a stalled rr_ready.
    reset = 1'b1; step(); step(); reset = 1'b0; step(); step();
    rr_ready = 1'b0;
    for (int c = 0; c < NCH; c++) exp_rr_q.push_back(rr_exp(c, 64'h4000 + 64'(c) * 64'h200));
    for (int c = 0; c < NCH; c++) wr(c, (64'h4000 + 64'(c) * 64'h200) | 64'h4);
    repeat (5) begin
      step();
      cmp("t2_stall_valid", 96'(rr_valid), 96'd1);
      cmp("t2_stall_chan", 96'(rr_chan), 96'd0);
      cmp("t2_stall_addr", 96'(rr_addr), 96'h4000);
    end
    rr_ready = 1'b1;
    acc_target += 4;
    wait_acc(acc_target);
    for (int c = 0; c < NCH; c++) exp_irq_q.push_back(8'(2*c+1));
    for (int c = 0; c < NCH; c++) rc_pulse(c);
    step(); step();

    // Byte-count match interrupt on channel 2.
    wr(2, 64'h21);
    wr(2, 64'h3_0002);
    wr(2, 64'h43);
    step(); step();
    cmp("t3_count", 96'(cnt(2)), 96'd8);
    exp_irq_q.push_back(8'd4);
    request_ack = 4'b0100;
    repeat (4) step();
    request_ack = '0;
    cmp("t3_match_early", 96'(interrupt[4]), 96'd0);
    step();
    cmp("t3_match_pulse", 96'(interrupt[4]), 96'd1);
    step();
    cmp("t3_match_single", 96'(interrupt[4]), 96'd0);
    cmp("t3_status", 96'(stat(2)), 96'h23);

    // Chained descriptor fetch on channel 0.
    exp_rr_q.push_back(rr_exp(0, 64'h2000));
    acc_target++;
    wr(0, 64'h2004);
    wait_acc(acc_target);
    exp_rr_q.push_back(rr_exp(0, 64'h3000));
    acc_target++;
    wvalid = 1'b1; wchan = 2'd0; wdata = 64'h3004;
    rc_last = 1'b1; rc_chan = 2'd0;
    step();
    wvalid = 1'b0; rc_last = 1'b0;
    cmp("t4_chain_not_idle", 96'(stat(0) & 32'h1), 96'd0);
    wait_acc(acc_target);
    step();
    exp_irq_q.push_back(8'd1);
    rc_pulse(0);
    cmp("t4_idle", 96'(stat(0)), 96'h1);
    cmp("t4_irq_before", 96'(interrupt[1]), 96'd0);
    step();
    cmp("t4_irq_pulse", 96'(interrupt[1]), 96'd1);
    step();

    // Abort on channel 3 mid-transfer with three queued entries.
    wr(3, 64'h5_0002);
    wr(3, 64'h2B);
    wr(3, 64'h6_0002);
    wr(3, 64'h43);
    wr(3, 64'h7_0002);
    cmp("t5_count", 96'(cnt(3)), 96'd5);
    cmp("t5_addr", 96'(raddr(3)), 96'h5_0000);
    wr(3, 64'h105);
    cmp("t5_abort_latency", 96'(cnt(3)), 96'd5);
    wr(3, 64'h43);
    cmp("t5_abort_count", 96'(cnt(3)), 96'd0);
    cmp("t5_abort_valid", 96'(request_valid[3]), 96'd0);
    cmp("t5_other_count", 96'(cnt(2)), 96'd4);
    wr(3, 64'h005);
    step(); step(); step();
    cmp("t5_flushed", 96'(cnt(3)), 96'd0);
    wr(3, 64'h8_0002);
    wr(3, 64'h13);
    step(); step();
    cmp("t5_resume_count", 96'(cnt(3)), 96'd2);
    cmp("t5_resume_addr", 96'(raddr(3)), 96'h8_0000);

    // Reset while a request is being offered.
    rr_ready = 1'b0;
    wr(1, 64'h5004);
    step(); step();
    cmp("t6_pre_valid", 96'(rr_valid), 96'd1);
    cmp("t6_pre_addr", 96'(rr_addr), 96'h5000);
    reset = 1'b1;
    step();
    check_reset_outputs("t6");
    step();
    cmp("t6_irq_in_reset", 96'(interrupt), 96'd0);
    reset = 1'b0;
    step();
    cmp("t6_irq_exit1", 96'(interrupt), 96'd0);
    step();
    cmp("t6_irq_exit2", 96'(interrupt), 96'd0);
    step();

    cmp("rr_queue_left", 96'(exp_rr_q.size()), 96'd0);
    cmp("irq_queue_left", 96'(exp_irq_q.size()), 96'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
